dht11_uart_report: RTL and testbench
====================================

# dht11_uart_report

Downstream stage of the DHT11 sensor reader. It captures the 16-bit `{temperature, humidity}` result when the reader pulses its ready strobe. It converts both bytes to 3-digit decimal ASCII and transmits a fixed-format text line over an 8N1 UART `tx` pin. This gives the host a human-readable report per measurement without any processing on its side.

## Interface
- `CLK_FREQ`, default 100000000: clock frequency in Hz.
- `BAUD`, default 9600: UART bit rate.
- `CLKS_PER_BIT`, default `CLK_FREQ/BAUD` (integer division, 10416 at the defaults): clocks per UART bit; must be ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `data_in`  in  16  measurement result: `[15:8]` is temperature (°C), `[7:0]` is humidity (%RH), both unsigned.
- `data_valid`  in  1  single-cycle strobe from the sensor reader; `data_in` is valid in the same cycle.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high from the capture until the line completes.
- `done`  out  1  single-cycle pulse when the last stop bit finishes.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, state=IDLE, all registers 0. Reset is asynchronous; reset during a frame forces `tx`=1 at once and aborts the line.
- **IDLE**
  - When `data_valid`=1 and `busy`=0 on a rising edge, latch `data_in`, set `busy`=1 and go to CONVERT.
  - A `data_valid` that arrives while `busy`=1 is dropped silently. No queue is kept.
- **CONVERT**
  - Runs for exactly 8 clocks.
  - A double-dabble shift-add converts each byte in parallel to 3 BCD digits (0–255 maps to "000"–"255").
- **LOAD**
  - Lasts 1 clock.
  - Selects the next message byte from the byte index (0..12) and loads the shift register.
- **START**: `tx`=0 for `CLKS_PER_BIT` clocks.
- **DATA**: 8 bits, LSB first, `CLKS_PER_BIT` clocks each.
- **STOP**: `tx`=1 for `CLKS_PER_BIT` clocks.
  - After STOP, if bytes remain, increment the index and return to LOAD.
  - After the last byte, go to IDLE.
- Message format is 13 bytes: `'T' '=' d2 d1 d0 ' ' 'H' '=' d2 d1 d0 CR LF`.
  - Each digit byte is 0x30 + the BCD digit.
  - d2 is the hundreds digit; leading zeros are always sent.
- The baud counter is internal, free of `data_in`, and restarts at every state entry. There is no fractional baud correction.

## Timing
- The capture edge is C.
- CONVERT occupies C+1..C+8 and LOAD occupies C+9.
- `tx` falls at edge C+10.
- Each byte lasts exactly `10*CLKS_PER_BIT` clocks, plus 1 LOAD clock between consecutive bytes. During LOAD `tx` stays 1, extending the previous stop bit.
- Total line time from C: `10 + 13*10*CLKS_PER_BIT + 12` clocks.
- **End of line** (the cycle after the final stop bit): `done`=1 for that one cycle, with `busy`=0 in the same cycle.
  - A `data_valid` in that cycle is accepted, so back-to-back lines are legal.
- `busy` is combinationally equal to (state ≠ IDLE) and is registered-state derived, with no glitches.

## Configuration
- Macro: `DHT11_REPORT_ERR_EN`.
- **Defined**: `data_in` == 16'h0000 is treated as the reader's error/checksum-fail code.
  - The message becomes 5 bytes, `'E' 'R' 'R' CR LF`.
  - The CONVERT timing is still 8 clocks.
  - Total line time is `10 + 5*10*CLKS_PER_BIT + 4` clocks.
- **Undefined**: 16'h0000 is formatted normally as "T=000 H=000\r\n".

## Test plan
- **Reset**: assert `rst_n`=0 mid-frame → `tx`=1, `busy`=0, `done`=0 immediately. After release, a new `data_valid` is accepted normally.
- **Normal line**: `CLKS_PER_BIT`=16, `data_in`=16'h1928 strobe → `tx` falls at C+10. The decoded bytes are 54 3D 30 32 35 20 48 3D 30 34 30 0D 0A, `done` pulses at C+10+13*160+12, and `busy` is low in that cycle.
- **Maximum values**: `data_in`=16'hFF00 → "T=255 H=000\r\n". Check every start and stop bit width is exactly 16 clocks.
- **Error code**:
  - With `DHT11_REPORT_ERR_EN`, 16'h0000 → 45 52 52 0D 0A and `done` at C+10+5*160+4.
  - Without it → "T=000 H=000\r\n".
- **Strobe while busy**: pulse `data_valid` with 16'h0102 mid-frame → it is ignored; the current line is unchanged and no second line follows.
- **Back-to-back**: pulse `data_valid`=16'h0A14 in the `done` cycle → the second line "T=010 H=020\r\n" starts at that capture +10 clocks.

Source files
------------

// File: rtl/dht11_uart_report.sv
// dht11_uart_report: formats a DHT11 {temperature, humidity} result as an
// ASCII line "T=ttt H=hhh\r\n" and sends it over an 8N1 UART.
// Optional build macro DHT11_REPORT_ERR_EN: a result of 16'h0000 is reported
// as "ERR\r\n" instead of being formatted.
module dht11_uart_report #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = ($clog2(CLKS_PER_BIT) > 4) ? $clog2(CLKS_PER_BIT) : 4;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(7);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CONVERT = 3'd1;
    localparam logic [2:0] LOAD    = 3'd2;
    localparam logic [2:0] START   = 3'd3;
    localparam logic [2:0] DATA    = 3'd4;
    localparam logic [2:0] STOP    = 3'd5;

    logic [2:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_d;
    logic [3:0]       byte_idx, byte_d;
    logic [7:0]       shreg, shreg_d;
    logic [7:0]       t_bin, t_bin_d, h_bin, h_bin_d;
    logic [11:0]      t_bcd, t_bcd_d, h_bcd, h_bcd_d;
    logic             tx_d, done_d;
    logic             is_err;
    logic [3:0]       last_idx;

`ifdef DHT11_REPORT_ERR_EN
    logic err_q, err_d;
    assign is_err = err_q;
`else
    assign is_err = 1'b0;
`endif

    assign last_idx = is_err ? 4'd4 : 4'd12;
    assign busy     = (state != IDLE);

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit
    function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic bin_msb);
        logic [11:0] a;
        a = bcd;
        for (int i = 0; i < 3; i++) begin
            if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
        end
        return {a[10:0], bin_msb};
    endfunction

    // Message byte for a given index
    function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic err,
                                            input logic [11:0] t, input logic [11:0] h);
        logic [7:0] b;
        if (err) begin
            case (idx)
                4'd0:    b = 8'h45;
                4'd1:    b = 8'h52;
                4'd2:    b = 8'h52;
                4'd3:    b = 8'h0D;
                default: b = 8'h0A;
            endcase
        end else begin
            case (idx)
                4'd0:    b = 8'h54;
                4'd1:    b = 8'h3D;
                4'd2:    b = {4'h3, t[11:8]};
                4'd3:    b = {4'h3, t[7:4]};
                4'd4:    b = {4'h3, t[3:0]};
                4'd5:    b = 8'h20;
                4'd6:    b = 8'h48;
                4'd7:    b = 8'h3D;
                4'd8:    b = {4'h3, h[11:8]};
                4'd9:    b = {4'h3, h[7:4]};
                4'd10:   b = {4'h3, h[3:0]};
                4'd11:   b = 8'h0D;
                default: b = 8'h0A;
            endcase
        end
        return b;
    endfunction

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            t_bin    <= '0;
            h_bin    <= '0;
            t_bcd    <= '0;
            h_bcd    <= '0;
            tx       <= 1'b1;
            done     <= 1'b0;
`ifdef DHT11_REPORT_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_d;
            byte_idx <= byte_d;
            shreg    <= shreg_d;
            t_bin    <= t_bin_d;
            h_bin    <= h_bin_d;
            t_bcd    <= t_bcd_d;
            h_bcd    <= h_bcd_d;
            tx       <= tx_d;
            done     <= done_d;
`ifdef DHT11_REPORT_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    // Next-state and output logic; tx is registered from the current state so the
    // line lags the state by one clock, and the final LOAD visit closes the line.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        byte_d  = byte_idx;
        shreg_d = shreg;
        t_bin_d = t_bin;
        h_bin_d = h_bin;
        t_bcd_d = t_bcd;
        h_bcd_d = h_bcd;
        tx_d    = 1'b1;
        done_d  = 1'b0;
`ifdef DHT11_REPORT_ERR_EN
        err_d   = err_q;
`endif
        case (state)
            IDLE: begin
                if (data_valid) begin
                    t_bin_d = data_in[15:8];
                    h_bin_d = data_in[7:0];
                    t_bcd_d = '0;
                    h_bcd_d = '0;
                    byte_d  = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
`ifdef DHT11_REPORT_ERR_EN
                    err_d   = (data_in == 16'h0000);
`endif
                end
            end
            CONVERT: begin
                t_bcd_d = dd_step(t_bcd, t_bin[7]);
                h_bcd_d = dd_step(h_bcd, h_bin[7]);
                t_bin_d = {t_bin[6:0], 1'b0};
                h_bin_d = {h_bin[6:0], 1'b0};
                cnt_d   = cnt + CNT_W'(1);
                if (cnt == CONV_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d = '0;
                if (byte_idx > last_idx) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    shreg_d = msg_byte(byte_idx, is_err, t_bcd, h_bcd);
                    state_d = START;
                end
            end
            START: begin
                tx_d  = 1'b0;
                cnt_d = cnt + CNT_W'(1);
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d  = shreg[0];
                cnt_d = cnt + CNT_W'(1);
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg[7:1]};
                    bit_d   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    byte_d  = byte_idx + 4'd1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dht11_uart_report.sv
// Bench for dht11_uart_report: directed and random measurement lines checked
// clock-by-clock against a waveform built from the expected message text.
module tb_dht11_uart_report;

    localparam int CPB = 16;
    localparam int PER = 10 * CPB + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        data_valid = 1'b0;
    logic        tx, busy, done;

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_b [13];
    int         exp_n;

    dht11_uart_report #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .data_valid(data_valid),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected text of a report line, computed with decimal arithmetic
    task automatic build_exp(input logic [15:0] d);
        int tv, hv;
        tv = int'(d[15:8]);
        hv = int'(d[7:0]);
`ifdef DHT11_REPORT_ERR_EN
        if (d == 16'h0000) begin
            exp_b[0] = "E"; exp_b[1] = "R"; exp_b[2] = "R";
            exp_b[3] = 8'h0D; exp_b[4] = 8'h0A;
            exp_n = 5;
            return;
        end
`endif
        exp_b[0]  = "T";
        exp_b[1]  = "=";
        exp_b[2]  = 8'(48 + tv / 100);
        exp_b[3]  = 8'(48 + (tv / 10) % 10);
        exp_b[4]  = 8'(48 + tv % 10);
        exp_b[5]  = " ";
        exp_b[6]  = "H";
        exp_b[7]  = "=";
        exp_b[8]  = 8'(48 + hv / 100);
        exp_b[9]  = 8'(48 + (hv / 10) % 10);
        exp_b[10] = 8'(48 + hv % 10);
        exp_b[11] = 8'h0D;
        exp_b[12] = 8'h0A;
        exp_n = 13;
    endtask

    // Expected tx level o clocks after the capture edge
    function automatic logic exp_tx(input int o);
        int b, w, p;
        if (o < 10) return 1'b1;
        b = (o - 10) / PER;
        w = (o - 10) % PER;
        if (b >= exp_n || w >= 10 * CPB) return 1'b1;
        p = w / CPB;
        if (p == 0) return 1'b0;
        if (p <= 8) return exp_b[b][p-1];
        return 1'b1;
    endfunction

    // Capture one measurement and follow its whole line
    task automatic run_line(input logic [15:0] d, input bit predriven,
                            input int mid_o, input logic [15:0] mid_d,
                            input bit chain, input logic [15:0] chain_d);
        int fin, wave_mis, bd_mis, b, w;
        logic [7:0] rx;
        build_exp(d);
        fin = 10 + exp_n * PER - 1;
        if (!predriven) begin
            data_in    = d;
            data_valid = 1'b1;
        end
        tick();
        data_valid = 1'b0;
        check("busy_after_capture", 32'(busy), 32'd1);
        check("tx_idle_after_capture", 32'(tx), 32'd1);
        wave_mis = 0;
        bd_mis   = 0;
        rx       = 8'h00;
        for (int o = 1; o <= fin; o++) begin
            tick();
            if (tx !== exp_tx(o)) wave_mis++;
            if (o < fin && (busy !== 1'b1 || done !== 1'b0)) bd_mis++;
            if (o >= 10) begin
                b = (o - 10) / PER;
                w = (o - 10) % PER;
                if (w >= CPB + CPB / 2 && w < 9 * CPB && (w - CPB - CPB / 2) % CPB == 0)
                    rx[3'((w - CPB - CPB / 2) / CPB)] = tx;
                if (w == 10 * CPB - 1) begin
                    check($sformatf("rx_byte%0d_%04h", b, d), 32'(rx), 32'(exp_b[b]));
                    check($sformatf("tx_wave_byte%0d_%04h", b, d), 32'(wave_mis), 32'd0);
                    wave_mis = 0;
                end
            end
            if (mid_o != 0 && o == mid_o) begin
                data_in    = mid_d;
                data_valid = 1'b1;
            end
            if (mid_o != 0 && o == mid_o + 1) data_valid = 1'b0;
        end
        check("tx_wave_tail", 32'(wave_mis), 32'd0);
        check("busy_done_trace", 32'(bd_mis), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
        if (chain) begin
            data_in    = chain_d;
            data_valid = 1'b1;
        end
    endtask

    // Line must stay idle for n clocks
    task automatic idle_check(input int n);
        int mis;
        mis = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) mis++;
        end
        check("idle_quiet", 32'(mis), 32'd0);
    endtask

    initial begin
        logic [15:0] rd;

        // Reset state
        tick(); tick();
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        idle_check(5);

        // Asynchronous reset in the middle of a start bit
        data_in    = 16'h1928;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("tx_low_before_reset", 32'(tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        idle_check(20);

        // Normal line, maximum value, zero value
        run_line(16'h1928, 1'b0, 0, 16'h0000, 1'b0, 16'h0000);
        idle_check(5);
        run_line(16'hFF00, 1'b0, 0, 16'h0000, 1'b0, 16'h0000);
        idle_check(5);
        run_line(16'h0000, 1'b0, 0, 16'h0000, 1'b0, 16'h0000);
        idle_check(5);

        // Strobe while busy is dropped and no second line follows
        run_line(16'h6355, 1'b0, 500, 16'h0102, 1'b0, 16'h0000);
        idle_check(400);

        // Back-to-back: new strobe in the done cycle
        rd = 16'($urandom);
        run_line(rd, 1'b0, 0, 16'h0000, 1'b1, 16'h0A14);
        run_line(16'h0A14, 1'b1, 0, 16'h0000, 1'b0, 16'h0000);
        idle_check(3);

        // Random measurements
        for (int k = 0; k < 3; k++) begin
            rd = 16'($urandom);
            run_line(rd, 1'b0, 0, 16'h0000, 1'b0, 16'h0000);
            idle_check(int'($urandom_range(6, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
